// File: rtl/stopwatch_controller.sv
// Sequencer for cascaded MM:SS seconds/minutes counters: decodes button pulses and the 1 Hz tick.
// One-cycle latency from input pulse to registered control pulse; no backpressure, every pulse is acted on or dropped.
module stopwatch_controller #(
    parameter int WIDTH     = 6,
    parameter int MAX_VALUE = 59
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             btn_start_stop,
    input  logic             btn_reset,
    input  logic             btn_set,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             mode_select,
    input  logic [WIDTH-1:0] sec_value,
    input  logic [WIDTH-1:0] min_value,
    output logic             sec_clear,
    output logic             sec_mode,
    output logic             sec_count,
    output logic             sec_inc,
    output logic             sec_dec,
    output logic             min_clear,
    output logic             min_mode,
    output logic             min_count,
    output logic             min_inc,
    output logic             min_dec,
    output logic             alarm,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PAUSE   = 3'd2,
        S_SET_SEC = 3'd3,
        S_SET_MIN = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t state_q, state_d;
    logic   run_mode_q, run_mode_d;
    logic   clear_q, clear_d;
    logic   sec_count_q, sec_count_d;
    logic   min_count_q, min_count_d;
    logic   sec_inc_q, sec_inc_d;
    logic   sec_dec_q, sec_dec_d;
    logic   min_inc_q, min_inc_d;
    logic   min_dec_q, min_dec_d;
    logic   alarm_q, alarm_d;

    logic act_reset, act_ss, act_set, act_up, act_dn;
    logic sec_zero, sec_max, both_zero;

    // Only the highest-priority button of a cycle survives this decode.
    assign act_reset = btn_reset;
    assign act_ss    = !btn_reset && btn_start_stop;
    assign act_set   = !btn_reset && !btn_start_stop && btn_set;
    assign act_up    = !btn_reset && !btn_start_stop && !btn_set && btn_up;
    assign act_dn    = !btn_reset && !btn_start_stop && !btn_set && !btn_up && btn_down;

    assign sec_zero  = (sec_value == '0);
    assign sec_max   = (sec_value == WIDTH'(MAX_VALUE));
    assign both_zero = sec_zero && (min_value == '0);

    always_comb begin
        state_d     = state_q;
        run_mode_d  = run_mode_q;
        clear_d     = 1'b0;
        sec_count_d = 1'b0;
        min_count_d = 1'b0;
        sec_inc_d   = 1'b0;
        sec_dec_d   = 1'b0;
        min_inc_d   = 1'b0;
        min_dec_d   = 1'b0;

        if (act_reset) begin
            clear_d = 1'b1;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (act_ss) begin
                        if (!(mode_select && both_zero)) begin
                            state_d    = S_RUN;
                            run_mode_d = mode_select;
                        end
                    end else if (act_set) begin
                        state_d = S_SET_SEC;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        if (run_mode_q && both_zero) begin
                            state_d = S_DONE;
                        end else begin
                            sec_count_d = 1'b1;
                            min_count_d = run_mode_q ? sec_zero : sec_max;
                        end
                    end
                    // A coincident start_stop still pauses after the tick is counted.
                    if (act_ss) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (act_ss) begin
                        state_d = S_RUN;
                    end
                end
                S_SET_SEC: begin
                    if (act_set) begin
                        state_d = S_SET_MIN;
                    end else if (act_up) begin
                        sec_inc_d = 1'b1;
                    end else if (act_dn) begin
                        sec_dec_d = 1'b1;
                    end
                end
                S_SET_MIN: begin
                    if (act_set) begin
                        state_d = S_IDLE;
                    end else if (act_up) begin
                        min_inc_d = 1'b1;
                    end else if (act_dn) begin
                        min_dec_d = 1'b1;
                    end
                end
                S_DONE: begin
                    if (act_ss) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        alarm_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            run_mode_q  <= 1'b0;
            clear_q     <= 1'b0;
            sec_count_q <= 1'b0;
            min_count_q <= 1'b0;
            sec_inc_q   <= 1'b0;
            sec_dec_q   <= 1'b0;
            min_inc_q   <= 1'b0;
            min_dec_q   <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_mode_q  <= run_mode_d;
            clear_q     <= clear_d;
            sec_count_q <= sec_count_d;
            min_count_q <= min_count_d;
            sec_inc_q   <= sec_inc_d;
            sec_dec_q   <= sec_dec_d;
            min_inc_q   <= min_inc_d;
            min_dec_q   <= min_dec_d;
            alarm_q     <= alarm_d;
        end
    end

    assign sec_clear = clear_q;
    assign min_clear = clear_q;
    assign sec_mode  = run_mode_q;
    assign min_mode  = run_mode_q;
    assign sec_count = sec_count_q;
    assign min_count = min_count_q;
    assign sec_inc   = sec_inc_q;
    assign sec_dec   = sec_dec_q;
    assign min_inc   = min_inc_q;
    assign min_dec   = min_dec_q;
    assign alarm     = alarm_q;
    assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller: directed vector table, async-reset sequence, random run vs reference model.
module tb_stopwatch_controller;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_RST  = 5'b10000;
    localparam logic [4:0] B_SS   = 5'b01000;
    localparam logic [4:0] B_SET  = 5'b00100;
    localparam logic [4:0] B_UP   = 5'b00010;
    localparam logic [4:0] B_DN   = 5'b00001;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       btn_start_stop, btn_reset, btn_set, btn_up, btn_down;
    logic       mode_select;
    logic [5:0] sec_value, min_value;
    logic       sec_clear, sec_mode, sec_count, sec_inc, sec_dec;
    logic       min_clear, min_mode, min_count, min_inc, min_dec;
    logic       alarm;
    logic [2:0] state;

    stopwatch_controller #(.WIDTH(6), .MAX_VALUE(59)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick),
        .btn_start_stop(btn_start_stop), .btn_reset(btn_reset), .btn_set(btn_set),
        .btn_up(btn_up), .btn_down(btn_down), .mode_select(mode_select),
        .sec_value(sec_value), .min_value(min_value),
        .sec_clear(sec_clear), .sec_mode(sec_mode), .sec_count(sec_count),
        .sec_inc(sec_inc), .sec_dec(sec_dec),
        .min_clear(min_clear), .min_mode(min_mode), .min_count(min_count),
        .min_inc(min_inc), .min_dec(min_dec),
        .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    logic [13:0] act;
    assign act = {state, alarm, sec_clear, min_clear, sec_mode, min_mode,
                  sec_count, min_count, sec_inc, sec_dec, min_inc, min_dec};

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] btn;
        logic       tk;
        logic       mode;
        logic [5:0] sec;
        logic [5:0] min;
        logic [2:0] st;
        logic       al, clr, md, sc, mc, si, sd, mi, mdn;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] b, input logic tk, input logic mode,
                                input int s, input int m, input int st,
                                input logic al, input logic clr, input logic md,
                                input logic sc, input logic mc, input logic si,
                                input logic sd, input logic mi, input logic mdn);
        vec_t v;
        v.btn = b; v.tk = tk; v.mode = mode; v.sec = 6'(s); v.min = 6'(m); v.st = 3'(st);
        v.al = al; v.clr = clr; v.md = md; v.sc = sc; v.mc = mc;
        v.si = si; v.sd = sd; v.mi = mi; v.mdn = mdn;
        return v;
    endfunction

    function automatic logic [13:0] exp_of(input vec_t v);
        return {v.st, v.al, v.clr, v.clr, v.md, v.md, v.sc, v.mc, v.si, v.sd, v.mi, v.mdn};
    endfunction

    task automatic check(input string name, input logic [13:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %b expected %b (state,alarm,clr_s,clr_m,mode_s,mode_m,cnt_s,cnt_m,inc_s,dec_s,inc_m,dec_m)",
                     name, act, expv);
        end
    endtask

    task automatic apply(input logic [4:0] b, input logic tk, input logic md,
                         input logic [5:0] s, input logic [5:0] m);
        {btn_reset, btn_start_stop, btn_set, btn_up, btn_down} = b;
        tick        = tk;
        mode_select = md;
        sec_value   = s;
        min_value   = m;
        @(posedge clk);
        #1;
    endtask

    // Reference model: abstract stopwatch state and latched direction.
    int   m_st;
    logic m_rm;

    task automatic model_step(input logic [4:0] b, input logic tk, input logic md,
                              input logic [5:0] s, input logic [5:0] m,
                              output logic [13:0] expv);
        int   win = -1;
        int   nxt;
        logic clr = 0, sc = 0, mc = 0, si = 0, sd = 0, mi = 0, mdn = 0;
        for (int i = 4; i >= 0; i--) begin
            if (b[i] && win < 0) win = i;
        end
        nxt = m_st;
        if (win == 4) begin
            clr = 1;
            nxt = 0;
        end else begin
            if (m_st == 1 && tk) begin
                if (m_rm && (int'(s) + int'(m)) == 0) nxt = 5;
                else begin
                    sc = 1;
                    mc = m_rm ? (s == 0) : (s == 59);
                end
            end
            if (win == 3) begin
                if (m_st == 0 && !(md && s == 0 && m == 0)) begin nxt = 1; m_rm = md; end
                else if (m_st == 1) nxt = 2;
                else if (m_st == 2) nxt = 1;
                else if (m_st == 5) nxt = 0;
            end else if (win == 2) begin
                if (m_st == 0) nxt = 3;
                else if (m_st == 3) nxt = 4;
                else if (m_st == 4) nxt = 0;
            end else if (win == 1) begin
                si = (m_st == 3);
                mi = (m_st == 4);
            end else if (win == 0) begin
                sd = (m_st == 3);
                mdn = (m_st == 4);
            end
        end
        m_st = nxt;
        expv = {3'(nxt), nxt == 5, clr, clr, m_rm, m_rm, sc, mc, si, sd, mi, mdn};
    endtask

    function automatic logic [5:0] pick_val();
        case ($urandom_range(0, 4))
            0: return 6'd0;
            1: return 6'd1;
            2: return 6'd58;
            3: return 6'd59;
            default: return 6'($urandom_range(0, 59));
        endcase
    endfunction

    vec_t tbl[$];

    initial begin
        reset_n = 1'b0;
        {btn_reset, btn_start_stop, btn_set, btn_up, btn_down} = B_NONE;
        tick = 0; mode_select = 0; sec_value = 0; min_value = 0;
        #12;
        check("reset_state", 14'd0);
        @(negedge clk);
        reset_n = 1'b1;

        //             btn         tk mo sec min st al cl md sc mc si sd mi mdn
        tbl.push_back(mk(B_NONE,     0, 0,  5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_SET,      0, 0,  5, 5, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_UP,       0, 0,  5, 5, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(B_UP,       0, 0,  5, 5, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(B_NONE,     1, 0,  5, 5, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_SET,      0, 0,  5, 5, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_DN,       0, 0,  5, 5, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(B_SET,      0, 0,  5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_SS,       0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_SS,       0, 1,  1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_NONE,     1, 0,  1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_NONE,     0, 0,  0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_NONE,     1, 0,  0, 0, 5, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_NONE,     0, 0,  0, 0, 5, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_SS,       0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_SS,       0, 0, 59, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_NONE,     1, 0, 59, 3, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(B_NONE,     0, 0,  0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_NONE,     1, 0, 59,59, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(B_NONE,     0, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_SS,       1, 0, 10, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_NONE,     0, 0, 10, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_NONE,     1, 0, 10, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_RST|B_SS, 0, 0, 10, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_NONE,     0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_SS|B_SET, 0, 0,  5, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_RST,      0, 0,  5, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_SS,       0, 1,  0, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_NONE,     1, 1,  0, 5, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(B_NONE,     0, 1, 59, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_NONE,     1, 1, 30, 5, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_RST,      0, 1, 30, 5, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_SET,      0, 0,  5, 5, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_UP|B_DN,  0, 0,  5, 5, 3, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(B_SS|B_UP,  0, 0,  5, 5, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_SET,      0, 0,  5, 5, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_UP,       0, 0,  5, 5, 4, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(B_SET,      0, 0,  5, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].btn, tbl[i].tk, tbl[i].mode, tbl[i].sec, tbl[i].min);
            check($sformatf("vec%0d", i), exp_of(tbl[i]));
        end

        // Asynchronous reset while a count pulse is on the outputs.
        apply(B_SS, 0, 0, 6'd5, 6'd5);
        check("run_entry", {3'd1, 11'b0});
        apply(B_NONE, 1, 0, 6'd5, 6'd5);
        check("run_tick", {3'd1, 5'b0, 1'b1, 5'b0});
        #2 reset_n = 1'b0;
        #1 check("async_reset_immediate", 14'd0);
        @(negedge clk);
        reset_n = 1'b1;
        apply(B_NONE, 0, 0, 6'd5, 6'd5);
        apply(B_NONE, 1, 0, 6'd5, 6'd5);
        check("tick_after_reset", 14'd0);

        m_st = 0;
        m_rm = 1'b0;
        begin
            logic        last_tk = 1'b0;
            logic [4:0]  b;
            logic        tk, md;
            logic [5:0]  s, m;
            logic [13:0] expv;
            for (int n = 0; n < 800; n++) begin
                b = 5'b0;
                for (int k = 0; k < 4; k++) b[k] = ($urandom_range(0, 5) == 0);
                b[4] = ($urandom_range(0, 24) == 0);
                tk = last_tk ? 1'b0 : ($urandom_range(0, 2) == 0);
                md = 1'($urandom_range(0, 1));
                s  = pick_val();
                m  = ($urandom_range(0, 2) == 0) ? 6'd0 : pick_val();
                model_step(b, tk, md, s, m, expv);
                apply(b, tk, md, s, m);
                check($sformatf("rand%0d", n), expv);
                last_tk = tk;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_controller.md
# stopwatch_controller

Sequencing controller for two cascaded 6-bit `BinaryUpCounter` instances, one for seconds and one for minutes, forming an MM:SS stopwatch/countdown timer. It decodes single-cycle button pulses and a 1 Hz tick. It drives each counter's `clear`, `mode`, `count`, `manual_increment` and `manual_decrement` inputs, and reads back their values to detect cascade and terminal conditions. It sits between the button debouncers and the counter/display datapath.

## Interface
- `WIDTH`, 6: counter value width.
- `MAX_VALUE`, 59: terminal count of each counter; counters wrap MAX_VALUE<->0.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle 1 Hz enable pulse; consecutive ticks are at least 2 cycles apart.
- `btn_start_stop`, `btn_reset`, `btn_set`, `btn_up`, `btn_down` in 1 each: debounced one-cycle pulses.
- `mode_select` in 1: 0 = count up (stopwatch), 1 = count down (timer); sampled on IDLE->RUN.
- `sec_value`, `min_value` in WIDTH: current counter outputs.
- `sec_clear`, `sec_mode`, `sec_count`, `sec_inc`, `sec_dec` out 1 each: seconds counter controls.
- `min_clear`, `min_mode`, `min_count`, `min_inc`, `min_dec` out 1 each: minutes counter controls.
- `alarm` out 1: high while in DONE.
- `state` out 3: IDLE=0, RUN=1, PAUSE=2, SET_SEC=3, SET_MIN=4, DONE=5.

## Operation
- **Counter contract:** on a clock edge with `count`=1, a counter steps +1 (mode 0) or -1 (mode 1) with wrap. `clear` zeroes it synchronously. `manual_increment`/`manual_decrement` step it once, independent of mode.
- **Mode latch:** `run_mode` captures `mode_select` on IDLE->RUN. `sec_mode` and `min_mode` always equal `run_mode`.
- **Button priority within one cycle:** reset > start_stop > set > up > down. Only the highest-priority pulse is acted on.
- **btn_reset (any state):** pulse `sec_clear` and `min_clear` for 1 cycle; go to IDLE. This aborts RUN/SET/DONE.
- **IDLE:**
  - start_stop -> RUN, except in down mode with both values 0, which is ignored.
  - set -> SET_SEC.
- **RUN:**
  - On tick, pulse `sec_count`.
  - In the same cycle, pulse `min_count` if `sec_value`==MAX_VALUE (up) or `sec_value`==0 (down).
  - Down mode, tick with both values 0: no count pulses; go to DONE.
  - Up mode at 59:59: wraps to 00:00 and keeps running.
  - start_stop -> PAUSE.
- **PAUSE:**
  - Ticks are ignored.
  - start_stop -> RUN; `run_mode` is not re-sampled.
- **SET_SEC / SET_MIN:**
  - up/down pulse `*_inc`/`*_dec` of the selected counter for 1 cycle.
  - set advances SET_SEC->SET_MIN->IDLE.
  - start_stop is ignored.
  - Ticks are ignored.
- **DONE:**
  - `alarm`=1.
  - start_stop -> IDLE, counters retained.
  - reset clears the counters as above.
- **Tick together with a button in RUN:** the tick's count pulses are issued, and the button's transition also takes effect.
- Never drive `*_count` and `*_inc`/`*_dec` in the same cycle.

## Timing
- All outputs are registered.
- **Reset values:**
  - `state`=IDLE, `run_mode`=0.
  - All counter controls 0.
  - `alarm`=0.
- **Latency:**
  - A button or tick in cycle t produces its control pulse in cycle t+1, exactly one cycle wide.
  - The counter updates at the end of t+1.
- **Cascade:** decisions in cycle t use `sec_value`/`min_value` sampled in cycle t. These are stable because no pulse is issued in cycle t (ticks are spaced ≥2 cycles).
- `state` changes at the edge ending cycle t; the `state` output shows the new state in t+1.
- **reset_n deasserted mid-run:**
  - Every output drops immediately.
  - After release, the block resumes in IDLE.
  - Counter contents are not touched.

## Test plan
- **Reset:** drop `reset_n` during RUN with `sec_count` high -> all outputs 0 immediately, `state`=0. After release, a tick causes no `sec_count`.
- **Up cascade:** IDLE, `mode_select`=0, start_stop, `sec_value`=59, `min_value`=3, tick at cycle t -> `sec_count`=`min_count`=1 in t+1 only, `sec_mode`=0, then `state`=1.
- **Down terminal:** `mode_select`=1, values 00:01, start, two ticks -> first tick gives `sec_count` only (min stays 0 since `sec_value`≠0). At the second tick, with both values 0 -> no count pulses, `state`=5, `alarm`=1. start_stop -> `state`=0, `alarm`=0.
- **Set:** set, up, up, set, down, set -> `sec_inc` two single-cycle pulses, `min_dec` one pulse, `state` 3->4->0. A tick during SET produces no count.
- **Priority:** `btn_reset` and `btn_start_stop` in the same cycle in PAUSE -> `sec_clear`=`min_clear`=1 for one cycle, `state`=0, no RUN.
- **Edge cases:**
  - Start in down mode at 00:00 -> `state` stays 0.
  - A tick coincident with start_stop in RUN -> `sec_count` pulse, then `state`=2.
